// File: rtl/bomb_pkg.sv
// Shared bomb-game definitions: controller game_state codes and the tick generator's
// state encoding. The controller and countdown block import the same constants.
package bomb_pkg;

  localparam logic [7:0] GS_INIT     = 8'h00;
  localparam logic [7:0] GS_ARMED    = 8'h10;
  localparam logic [7:0] GS_DEFUSED  = 8'h20;
  localparam logic [7:0] GS_EXPLODED = 8'h30;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_RUN  = 2'd1,
    TS_HOLD = 2'd2,
    TS_DONE = 2'd3
  } tick_state_t;

  // Defused and exploded both end the round and freeze the timebase.
  function automatic logic gs_is_final(input logic [7:0] gs);
    return (gs == GS_DEFUSED) || (gs == GS_EXPLODED);
  endfunction

endpackage

// File: rtl/sec_tick_gen_if.sv
// Controller-facing bundle of the tick generator: game inputs in, timebase outputs out.
interface sec_tick_gen_if;

  logic [7:0] game_state;
  logic [1:0] strikes;
  logic       sec_timer;
  logic       half_tick;
  logic       blink;
  logic [7:0] elapsed;

  modport master (
    output game_state, strikes,
    input  sec_timer, half_tick, blink, elapsed
  );

  modport slave (
    input  game_state, strikes,
    output sec_timer, half_tick, blink, elapsed
  );

endinterface

// File: rtl/tick_period_lut.sv
// Strike count to tick period P and half point H, in clock cycles. Every table entry
// is an elaboration-time constant, so this reduces to a 4:1 mux.
module tick_period_lut #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 26
) (
  input  logic [1:0]       i_strikes,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_half
);

  // Each strike shaves a quarter off the nominal second; CLK_HZ/4 must stay >= 2.
  localparam logic [CNT_W-1:0] P0 = CNT_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] P1 = CNT_W'(CLK_HZ * 3 / 4);
  localparam logic [CNT_W-1:0] P2 = CNT_W'(CLK_HZ / 2);
  localparam logic [CNT_W-1:0] P3 = CNT_W'(CLK_HZ / 4);

  always_comb begin
    o_period = P0;
    unique case (i_strikes)
      2'd0: o_period = P0;
      2'd1: o_period = P1;
      2'd2: o_period = P2;
      2'd3: o_period = P3;
    endcase
    o_half = o_period >> 1;
  end

endmodule

// File: rtl/sec_tick_gen.sv
// Countdown timebase: strike-scaled one-cycle second pulse, midpoint pulse, blink phase
// and a saturating tick count, advancing only while the game is armed.
module sec_tick_gen
  import bomb_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 26
) (
  input logic           clk,
  input logic           reset,
  sec_tick_gen_if.slave bus
);

  tick_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_period, w_half, w_last, w_mid;
  logic             r_sec, w_sec_nxt;
  logic             r_half, w_half_nxt;
  logic             r_blink, w_blink_nxt;
  logic [7:0]       r_elapsed, w_elapsed_nxt;
  logic             w_armed, w_final, w_init;

  tick_period_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .i_strikes (bus.strikes),
    .o_period  (w_period),
    .o_half    (w_half)
  );

  assign w_last  = w_period - CNT_W'(1);
  assign w_mid   = w_half - CNT_W'(1);
  assign w_armed = (bus.game_state == GS_ARMED);
  assign w_final = gs_is_final(bus.game_state);
  assign w_init  = (bus.game_state == GS_INIT);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sec_nxt     = 1'b0;
    w_half_nxt    = 1'b0;
    w_blink_nxt   = r_blink;
    w_elapsed_nxt = r_elapsed;
    unique case (r_state)
      TS_IDLE: begin
        w_cnt_nxt   = '0;
        w_blink_nxt = 1'b1;
        if (w_armed) begin
          w_state_nxt   = TS_RUN;
          w_elapsed_nxt = '0;
        end
      end
      TS_RUN: begin
        if (w_armed) begin
          // >= rather than == so a strike that shrinks P below cnt still ticks next cycle.
          if (r_cnt >= w_last) begin
            w_cnt_nxt     = '0;
            w_sec_nxt     = 1'b1;
            w_blink_nxt   = 1'b1;
            w_elapsed_nxt = (r_elapsed != 8'hFF) ? r_elapsed + 8'd1 : r_elapsed;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == w_mid) begin
              w_half_nxt  = 1'b1;
              w_blink_nxt = 1'b0;
            end
          end
        end else if (w_final) begin
          w_state_nxt = TS_DONE;
        end else begin
          w_state_nxt = TS_HOLD;
        end
      end
      TS_HOLD: begin
        if (w_armed)      w_state_nxt = TS_RUN;
        else if (w_final) w_state_nxt = TS_DONE;
      end
      TS_DONE: begin
        // Leaving DONE lands directly on the idle values; elapsed stays for the score display.
        if (w_init) begin
          w_state_nxt = TS_IDLE;
          w_cnt_nxt   = '0;
          w_blink_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= TS_IDLE;
      r_cnt     <= '0;
      r_sec     <= 1'b0;
      r_half    <= 1'b0;
      r_blink   <= 1'b1;
      r_elapsed <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sec     <= w_sec_nxt;
      r_half    <= w_half_nxt;
      r_blink   <= w_blink_nxt;
      r_elapsed <= w_elapsed_nxt;
    end
  end

  assign bus.sec_timer = r_sec;
  assign bus.half_tick = r_half;
  assign bus.blink     = r_blink;
  assign bus.elapsed   = r_elapsed;

endmodule
